div_r4_ctrl: RTL and testbench

Sequencing controller for the radix-4 SRT divide datapath. It accepts a dividend/divisor pair over a start/done handshake and seeds the partial remainder. Each cycle it drives the external quotient-digit LUT with the residual estimate and a divisor-indexed threshold set, then accumulates digits and residual for a fixed iteration count. It optionally applies a final sign correction and owns the programmable 8×4 threshold table.

---
 rtl/div_r4_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_div_r4_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_r4_ctrl.sv
// div_r4_ctrl -- sequencing controller for a radix-4 SRT divide datapath.
//
// Accepts a dividend/divisor pair over a start/done handshake and seeds the
// partial remainder w. Each ITER cycle it presents the residual estimate, the
// latched divisor and the divisor-indexed threshold set to an external
// quotient-digit LUT. It then folds the returned digit and -q*d back into Q and w.
// It also owns the programmable 8x4 threshold table.
//
// Configuration macro: DIV_CORRECT_EN
//   defined   : a CORR state makes rem non-negative and quo the truncated quotient
//   undefined : the raw signed w/Q are reported and latency is one cycle shorter
//
// Handshake: start_i is sampled only in IDLE. A start seen in any other state is
// ignored and is not remembered. done_o is a one-cycle pulse while in DONE.
// quo_o/rem_o/err_o are valid with done_o and hold until the next accepted start.
//
// Ports:
//   clk_i, reset_i        clock (rising edge), asynchronous active-high reset
//   start_i, x_i, d_i     request, dividend (WF+4 bits), divisor (WF+5 bits)
//   busy_o, done_o, err_o status; err_o flags a non-normalized divisor
//   quo_o, rem_o          signed quotient and final residual
//   cfg_we_i/addr_i/data_i threshold-table write, {index,sel}, honoured in IDLE
//   lut_en_o, lut_yhat_o, lut_m2_o..lut_mm1_o, lut_d_o   digit-LUT request
//   lut_q_i, lut_mqd_i    digit and -q*d returned by the LUT
//   state_o               current FSM state (debug observation)
module div_r4_ctrl #(
  parameter int WF    = 9,
  parameter int NITER = 7
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [WF+3:0]        x_i,
  input  logic [WF+4:0]        d_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2*NITER+1:0]   quo_o,
  output logic [WF+6:0]        rem_o,
  input  logic                 cfg_we_i,
  input  logic [4:0]           cfg_addr_i,
  input  logic [6:0]           cfg_data_i,
  output logic                 lut_en_o,
  output logic [6:0]           lut_yhat_o,
  output logic [6:0]           lut_m2_o,
  output logic [6:0]           lut_m1_o,
  output logic [6:0]           lut_m0_o,
  output logic [6:0]           lut_mm1_o,
  output logic [WF+4:0]        lut_d_o,
  input  logic [2:0]           lut_q_i,
  input  logic [WF+6:0]        lut_mqd_i,
  output logic [1:0]           state_o
);

  localparam int WW = WF + 7;
  localparam int QW = 2 * NITER + 2;
  localparam int CW = $clog2(NITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Reset contents of the threshold table, addressed as {index[2:0], sel[1:0]}.
  function automatic logic [6:0] thr_default(input logic [4:0] a);
    int v;
    v = 0;
    case (a[1:0])
      2'd0: case (a[4:2])
              3'd0: v = 12;  3'd1: v = 14;  3'd2: v = 15;  3'd3: v = 16;
              3'd4: v = 18;  3'd5: v = 20;  3'd6: v = 20;  default: v = 24;
            endcase
      2'd1: case (a[4:2])
              3'd0, 3'd1, 3'd2, 3'd3: v = 4;
              3'd4, 3'd5:             v = 6;
              default:                v = 8;
            endcase
      2'd2: case (a[4:2])
              3'd0:                         v = -4;
              3'd1, 3'd2, 3'd3, 3'd4:       v = -6;
              default:                      v = -8;
            endcase
      default: case (a[4:2])
              3'd0: v = -13; 3'd1: v = -15; 3'd2: v = -16; 3'd3: v = -18;
              3'd4: v = -20; 3'd5: v = -20; 3'd6: v = -22; default: v = -24;
            endcase
    endcase
    return v[6:0];
  endfunction

  state_t          state_q, state_d;
  logic [WW-1:0]   w_q;
  logic [QW-1:0]   q_q;
  logic [CW-1:0]   cnt_q;
  logic [WF+4:0]   d_q;
  logic [2:0]      idx_q;
  logic [QW-1:0]   quo_q;
  logic [WW-1:0]   rem_q;
  logic            err_q, busy_q, done_q, lut_en_q;
  logic [6:0]      tbl_q [32];

  logic            d_norm;
  logic            last_iter;
  logic [WW-1:0]   w4, w_next, w_init, w_corr;
  logic [QW-1:0]   q_next, q_corr;
  logic            unused_x_lsbs;

  assign d_norm    = !d_i[WF+4] && d_i[WF+3];
  assign last_iter = (cnt_q == CW'(NITER - 1));
  assign w4        = {w_q[WW-3:0], 2'b00};
  assign w_next    = w4 + lut_mqd_i;
  assign q_next    = {q_q[QW-3:0], 2'b00} + {{(QW-3){lut_q_i[2]}}, lut_q_i};
  // x sits at WF+4 fraction bits; the divide-by-4 drops its two lowest bits.
  assign w_init    = {{(WW-(WF+2)){1'b0}}, x_i[WF+3:2]};
  assign unused_x_lsbs = ^x_i[1:0];
  assign w_corr    = w_q + {{(WW-(WF+5)){1'b0}}, d_q};
  assign q_corr    = q_q - QW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = d_norm ? S_ITER : S_DONE;
      S_ITER: if (last_iter) begin
`ifdef DIV_CORRECT_EN
        state_d = S_CORR;
`else
        state_d = S_DONE;
`endif
      end
      S_CORR: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lut_en_q <= 1'b0;
      for (int i = 0; i < 32; i++) tbl_q[i] <= thr_default(5'(i));
    end else begin
      state_q  <= state_d;
      // Status flags are registered from the next state so they line up with state_q.
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      lut_en_q <= (state_d == S_ITER);
      case (state_q)
        S_IDLE: begin
          if (cfg_we_i) tbl_q[cfg_addr_i] <= cfg_data_i;
          if (start_i) begin
            if (d_norm) begin
              d_q   <= d_i;
              idx_q <= d_i[WF+2:WF];
              w_q   <= w_init;
              q_q   <= '0;
              cnt_q <= '0;
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
              quo_q <= '0;
              rem_q <= '0;
            end
          end
        end
        S_ITER: begin
          w_q   <= w_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CW'(1);
`ifndef DIV_CORRECT_EN
          if (last_iter) begin
            quo_q <= q_next;
            rem_q <= w_next;
          end
`endif
        end
        S_CORR: begin
          // A negative residual means the last digit overshot by one unit.
          if (w_q[WW-1]) begin
            w_q   <= w_corr;
            q_q   <= q_corr;
            quo_q <= q_corr;
            rem_q <= w_corr;
          end else begin
            quo_q <= q_q;
            rem_q <= w_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign quo_o      = quo_q;
  assign rem_o      = rem_q;
  assign state_o    = state_q;
  assign lut_en_o   = lut_en_q;
  // LUT request lines are quiet outside ITER.
  assign lut_yhat_o = lut_en_q ? w4[WW-1:WW-7] : '0;
  assign lut_m2_o   = lut_en_q ? tbl_q[{idx_q, 2'd0}] : '0;
  assign lut_m1_o   = lut_en_q ? tbl_q[{idx_q, 2'd1}] : '0;
  assign lut_m0_o   = lut_en_q ? tbl_q[{idx_q, 2'd2}] : '0;
  assign lut_mm1_o  = lut_en_q ? tbl_q[{idx_q, 2'd3}] : '0;
  assign lut_d_o    = lut_en_q ? d_q : '0;

endmodule

// File: tb/tb_div_r4_ctrl.sv
// tb_div_r4_ctrl -- self-checking bench for div_r4_ctrl (WF=9, NITER=7).
// Provides a behavioural digit-selection LUT. Expected quotient and remainder
// come from integer division of the seeded dividend by the divisor.
module tb_div_r4_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [12:0] x;
  logic [13:0] d;
  logic        busy, done, err;
  logic [15:0] quo, rem;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [6:0]  cfg_data;
  logic        lut_en;
  logic [6:0]  lut_yhat, lut_m2, lut_m1, lut_m0, lut_mm1;
  logic [13:0] lut_d;
  logic [2:0]  lut_q;
  logic [15:0] lut_mqd;
  logic [1:0]  state;

`ifdef DIV_CORRECT_EN
  localparam int LAT_OK = 9;
`else
  localparam int LAT_OK = 8;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int tbl_m[32];
  int cur_d = 0;

  div_r4_ctrl #(.WF(9), .NITER(7)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .x_i(x), .d_i(d),
    .busy_o(busy), .done_o(done), .err_o(err), .quo_o(quo), .rem_o(rem),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .lut_en_o(lut_en), .lut_yhat_o(lut_yhat), .lut_m2_o(lut_m2),
    .lut_m1_o(lut_m1), .lut_m0_o(lut_m0), .lut_mm1_o(lut_mm1),
    .lut_d_o(lut_d), .lut_q_i(lut_q), .lut_mqd_i(lut_mqd), .state_o(state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Behavioural digit-selection LUT: compare estimate against thresholds.
  int yh, sq;
  always_comb begin
    yh = int'($signed(lut_yhat));
    if      (yh >= int'($signed(lut_m2)))  sq = 2;
    else if (yh >= int'($signed(lut_m1)))  sq = 1;
    else if (yh >= int'($signed(lut_m0)))  sq = 0;
    else if (yh >= int'($signed(lut_mm1))) sq = -1;
    else                                   sq = -2;
    lut_q   = 3'(sq);
    lut_mqd = 16'(-sq * int'(lut_d));
  end

  task automatic check(input string tag, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  task automatic reset_tbl();
    int m2d[8]  = '{12, 14, 15, 16, 18, 20, 20, 24};
    int m1d[8]  = '{4, 4, 4, 4, 6, 6, 8, 8};
    int m0d[8]  = '{-4, -6, -6, -6, -6, -8, -8, -8};
    int mm1d[8] = '{-13, -15, -16, -18, -20, -20, -22, -24};
    for (int i = 0; i < 8; i++) begin
      tbl_m[i*4+0] = m2d[i];
      tbl_m[i*4+1] = m1d[i];
      tbl_m[i*4+2] = m0d[i];
      tbl_m[i*4+3] = mm1d[i];
    end
  endtask

  // Reference: w starts at floor(x/4) (13 fraction bits) and is scaled by 4^7,
  // so the truncated quotient is floor(16384*floor(x/4)/d).
  function automatic void model(input int xv, input int dv,
                                output int fq, output int fr, output int ee);
    int num;
    ee = (dv < 4096 || dv > 8191) ? 1 : 0;
    fq = 0;
    fr = 0;
    if (ee == 0) begin
      num = 16384 * (xv >> 2);
      fq  = num / dv;
      fr  = num % dv;
    end
  endfunction

  // Threshold/divisor presentation check on every ITER cycle.
  always @(negedge clk) begin
    if (!reset && lut_en) begin
      check("lut_m2",  int'($signed(lut_m2)),  tbl_m[((cur_d >> 9) & 7)*4+0]);
      check("lut_m1",  int'($signed(lut_m1)),  tbl_m[((cur_d >> 9) & 7)*4+1]);
      check("lut_m0",  int'($signed(lut_m0)),  tbl_m[((cur_d >> 9) & 7)*4+2]);
      check("lut_mm1", int'($signed(lut_mm1)), tbl_m[((cur_d >> 9) & 7)*4+3]);
      check("lut_d",   int'(lut_d), cur_d);
    end
  end

  // Drive one request; start is high across exactly one rising edge.
  task automatic issue(input int xv, input int dv);
    int fq, fr, ee;
    model(xv, dv, fq, fr, ee);
    exp_q.push_back(32'(fq));
    exp_q.push_back(32'(fr));
    exp_q.push_back(32'(ee));
    @(negedge clk);
    x = 13'(xv); d = 14'(dv); start = 1'b1;
    if (ee == 0) cur_d = dv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(input int exp_lat, input int dv, input bit disturb);
    int lat, fq, fr, ee, r;
    bit saw_en;
    lat = 1;
    saw_en = lut_en;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      saw_en |= lut_en;
      if (disturb && lat == 3) begin
        start = 1'b1; x = 13'd123; d = 14'd4100;
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 7'd5;
      end
      if (disturb && lat == 4) begin
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    check("latency", lat, exp_lat);
    fq = int'(exp_q.pop_front());
    fr = int'(exp_q.pop_front());
    ee = int'(exp_q.pop_front());
    if (!done) return;
    check("err", int'(err), ee);
    check("busy_in_done", int'(busy), 1);
    if (ee != 0) begin
      check("quo_err", int'($signed(quo)), 0);
      check("rem_err", int'($signed(rem)), 0);
      check("lut_en_err", int'(saw_en), 0);
    end else begin
`ifdef DIV_CORRECT_EN
      check("quo", int'($signed(quo)), fq);
      check("rem", int'($signed(rem)), fr);
`else
      // Uncorrected result is the floor result or one digit unit above it.
      r = int'($signed(rem));
      if (r < 0) begin
        check("quo_raw", int'($signed(quo)), fq + 1);
        check("rem_raw", r, fr - dv);
      end else begin
        check("quo_raw", int'($signed(quo)), fq);
        check("rem_raw", r, fr);
      end
`endif
    end
  endtask

  task automatic run_div(input int xv, input int dv, input bit disturb);
    issue(xv, dv);
    wait_done((dv < 4096 || dv > 8191) ? 1 : LAT_OK, dv, disturb);
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_data = 7'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    tbl_m[addr] = data;
  endtask

  initial begin
    int xv, dv, fq, fr, ee;
    reset = 1'b1; start = 1'b0; x = '0; d = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    reset_tbl();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_quo", int'(quo), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_lut_en", int'(lut_en), 0);
    check("rst_lut_m2", int'(lut_m2), 0);
    check("rst_state", int'(state), 0);
    reset = 1'b0;

    // Directed cases
    run_div(4096, 6144, 1'b0);
    run_div(8191, 4096, 1'b0);
    run_div(0, 5000, 1'b0);
    run_div(4096, 2048, 1'b0);
    run_div(100, 12000, 1'b0);
    run_div(8191, 8191, 1'b0);
    run_div(1, 4096, 1'b0);

    // Honoured table write in IDLE, then used by a divisor in index 7
    cfg_write(28, 23);
    run_div(5000, 8000, 1'b0);

    // start and cfg write mid-ITER are dropped
    run_div(4096, 6144, 1'b1);
    run_div(1000, 4200, 1'b0);

    // Reset during ITER discards the divide and restores the table
    issue(4096, 6144);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_quo", int'(quo), 0);
    check("midrst_state", int'(state), 0);
    check("midrst_lut_en", int'(lut_en), 0);
    exp_q.delete();
    reset_tbl();
    @(negedge clk);
    reset = 1'b0;
    run_div(4096, 6144, 1'b0);
    run_div(7000, 8000, 1'b0);

    // start during DONE is ignored, accepted on the following IDLE cycle
    run_div(3000, 5000, 1'b0);
    xv = 6000; dv = 7000;
    model(xv, dv, fq, fr, ee);
    exp_q.push_back(32'(fq));
    exp_q.push_back(32'(fr));
    exp_q.push_back(32'(ee));
    x = 13'(xv); d = 14'(dv); start = 1'b1; cur_d = dv;
    @(negedge clk);
    check("b2b_idle", int'(state), 0);
    check("b2b_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT_OK, dv, 1'b0);

    // Randomized divides, some with unnormalized divisors
    for (int i = 0; i < 30; i++) begin
      xv = int'($urandom_range(0, 8191));
      if (i % 6 == 5) dv = (i % 12 == 5) ? int'($urandom_range(0, 4095))
                                         : int'($urandom_range(8192, 16383));
      else            dv = int'($urandom_range(4096, 8191));
      run_div(xv, dv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
